// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, baud arithmetic and frame width.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } tx_state_t;

  // Clock cycles per line bit, truncated; the receive path uses the same value
  // so both ends agree on bit boundaries.
  function automatic int bit_period(input int clock_freq, input int baud);
    return clock_freq / baud;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO with a first-word-fall-through head output.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [7:0]               i_wdata,
  output logic [7:0]               o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A full FIFO refuses a push even when a pop lands on the same edge.
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage write; contents are only meaningful between pointers.
  // NOTE: the data array carries no reset -- the pointers and count define
  // validity, and leaving storage unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/transmitter.sv
// 8N1 UART transmitter: handshake into a byte FIFO, then start/data/stop
// serialisation on a registered txd line with back-to-back frames.
module transmitter
  import uart_pkg::*;
#(
  parameter int BAUD       = 115200,
  parameter int CLOCK_FREQ = 25_500_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          txd
);

  localparam int BIT_PERIOD = bit_period(CLOCK_FREQ, BAUD);
  localparam int CNT_W      = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
  localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

  tx_state_t        r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_txd;

  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_bit_end;

  assign in_ready  = !w_full;
  assign w_push    = in_valid && in_ready;
  assign w_bit_end = (r_baud_cnt == CNT_LAST);
  assign busy      = (r_state != IDLE) || !w_empty;
  assign txd       = r_txd;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (in_data),
    .o_rdata (w_head),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Pop the FIFO head exactly when the FSM starts a new frame.
  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      IDLE:     w_pop = !w_empty;
      STOP_BIT: w_pop = w_bit_end && !w_empty;
      default:  w_pop = 1'b0;
    endcase
  end

  // Frame sequencer, baud counter and registered line driver.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_txd      <= 1'b1;
          r_baud_cnt <= '0;
          if (!w_empty) begin
            r_shift <= w_head;
            r_txd   <= 1'b0;
            r_state <= START_BIT;
          end
        end

        START_BIT: begin
          if (w_bit_end) begin
            r_txd      <= r_shift[0];
            r_bit_idx  <= '0;
            r_baud_cnt <= '0;
            r_state    <= DATA_BITS;
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end

        DATA_BITS: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == IDX_LAST) begin
              r_txd   <= 1'b1;
              r_state <= STOP_BIT;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_txd     <= r_shift[r_bit_idx + 3'd1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end

        STOP_BIT: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            // Chain straight into the next start bit when data is waiting.
            if (!w_empty) begin
              r_shift <= w_head;
              r_txd   <= 1'b0;
              r_state <= START_BIT;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state    <= IDLE;
          r_txd      <= 1'b1;
          r_baud_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// Self-checking bench for the UART transmitter: a cycle-level behavioural model
// predicts txd/busy/fifo_count/in_ready, and a line receiver decodes txd.
module tb_transmitter;

  localparam int DEPTH = 4;
  localparam int BP    = 1000 / 100;
  localparam int FRAME = 10 * BP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       busy;
  logic [2:0] fifo_count;
  logic       txd;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: buffered bytes, the frame on the line and its start edge.
  int         m_t = 0;
  logic [7:0] m_q[$];
  bit         m_have = 0;
  int         m_start = 0;
  logic [7:0] m_byte = 8'h00;
  int         m_free_at = 0;

  logic [7:0] rx_q[$];
  logic [7:0] sent_q[$];

  transmitter #(
    .BAUD       (100),
    .CLOCK_FREQ (1000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .busy       (busy),
    .fifo_count (fifo_count),
    .txd        (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s at t=%0d: observed %0h expected %0h", tag, m_t, obs, exp);
    end
  endtask

  function automatic logic model_txd();
    int k;
    if (m_have && (m_t - m_start) < FRAME) begin
      k = (m_t - m_start) / BP;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return m_byte[k-1];
    end
    return 1'b1;
  endfunction

  function automatic logic model_busy();
    return (m_have && (m_t - m_start) < FRAME) || (m_q.size() != 0);
  endfunction

  // One clock edge: drive inputs, advance the model, compare all outputs.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r, output bit acc);
    bit do_pop;
    bit do_push;
    in_valid = v;
    in_data  = d;
    rst      = r;
    @(posedge clk);
    m_t++;
    acc = 1'b0;
    if (r) begin
      m_q.delete();
      m_have    = 1'b0;
      m_free_at = 0;
    end else begin
      do_push = v && (m_q.size() != DEPTH);
      do_pop  = (m_q.size() != 0) && (m_t >= m_free_at);
      if (do_pop) begin
        m_byte    = m_q.pop_front();
        m_start   = m_t;
        m_have    = 1'b1;
        m_free_at = m_t + FRAME;
      end
      if (do_push) begin
        m_q.push_back(d);
        sent_q.push_back(d);
      end
      acc = do_push;
    end
    #1;
    check("txd",        32'(txd),        32'(model_txd()));
    check("busy",       32'(busy),       32'(model_busy()));
    check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    check("in_ready",   32'(in_ready),   32'(m_q.size() != DEPTH));
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, acc);
  endtask

  task automatic push(input logic [7:0] d);
    bit acc;
    cycle(1'b1, d, 1'b0, acc);
  endtask

  // Line receiver: centre-samples each bit after a falling start edge.
  initial begin
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && txd === 1'b0) begin
        repeat (BP + BP / 2) @(negedge clk);
        b[0] = txd;
        for (int i = 1; i < 8; i++) begin
          repeat (BP) @(negedge clk);
          b[i] = txd;
        end
        repeat (BP) @(negedge clk);
        if (txd === 1'b1) rx_q.push_back(b);
        else              rx_q.push_back(~b);
      end
      prev = txd;
    end
  end

  initial begin
    bit         acc;
    int         guard;
    logic [7:0] d;

    // Reset state
    cycle(1'b0, 8'h00, 1'b1, acc);
    cycle(1'b0, 8'h00, 1'b1, acc);
    check("rst_txd",   32'(txd),        32'd1);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ready", 32'(in_ready),   32'd1);

    // 1: single 0xA5 from idle; txd still high right after the push edge
    push(8'hA5);
    check("t1_high_after_push", 32'(txd), 32'd1);
    idle(1);
    check("t1_low_at_e1", 32'(txd), 32'd0);
    idle(FRAME + 10);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // 2: four consecutive bytes, back-to-back frames
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    push(8'h0F);
    idle(4 * FRAME + 10);

    // 3: hold in_valid through a full FIFO; no loss or duplication
    for (int i = 0; i < 8; i++) begin
      guard = 0;
      do begin
        cycle(1'b1, 8'h10 + 8'(i), 1'b0, acc);
        guard++;
      end while (!acc && guard < 1000);
      if (!acc) check("t3_accept_timeout", 32'(guard), 32'd0);
    end
    idle(8 * FRAME + 10);

    // 4: reset at cycle 35 of a frame with bytes buffered
    push(8'h81);
    push(8'h42);
    push(8'h99);
    for (int k = 0; k < 200 && (m_t + 1 != m_start + 35); k++) idle(1);
    cycle(1'b0, 8'h00, 1'b1, acc);
    check("t4_txd",   32'(txd),        32'd1);
    check("t4_count", 32'(fifo_count), 32'd0);
    check("t4_busy",  32'(busy),       32'd0);
    idle(2 * FRAME);
    push(8'h3C);
    idle(FRAME + 10);

    // 6: simultaneous push and pop with three bytes buffered
    push(8'h61);
    push(8'h62);
    push(8'h63);
    push(8'h64);
    for (int k = 0; k < 300 && (m_t + 1 != m_start + FRAME); k++) idle(1);
    push(8'h70);
    check("t6_count", 32'(fifo_count), 32'd3);
    idle(5 * FRAME + 10);

    // 5: 256 random bytes through the looped-back receiver
    rx_q.delete();
    sent_q.delete();
    for (int i = 0; i < 256; i++) begin
      d     = 8'($urandom);
      guard = 0;
      do begin
        cycle(($urandom_range(0, 3) != 0), d, 1'b0, acc);
        guard++;
      end while (!acc && guard < 1000);
      if (!acc) check("t5_accept_timeout", 32'(guard), 32'd0);
    end
    idle(6 * FRAME);
    check("t5_rx_count", 32'(rx_q.size()), 32'(sent_q.size()));
    for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++) begin
      check($sformatf("t5_rx_byte%0d", i), 32'(rx_q[i]), 32'(sent_q[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
